// File: rtl/acq_sequencer.sv
// Multi-channel acquisition sequencer: decodes a command byte, then runs ramp/SAR/TX over NCH channels.
// Single-shot or 1 ms sweep mode, with per-wait watchdog, abort and busy/error reporting.
module acq_sequencer #(
  parameter int                 WIDTH      = 8,
  parameter int                 NCH        = 4,
  parameter logic [WIDTH-1:0]   CMD_SINGLE = 'h01,
  parameter logic [WIDTH-1:0]   CMD_SWEEP  = 'h02,
  parameter int                 TMO_W      = 16,
  parameter int                 TMO_CYC    = 50000,
  parameter int                 CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] cmd_buffer_i,
  input  logic             eor_i,
  input  logic             abort_i,
  input  logic             eosar_i,
  input  logic             eot_i,
  input  logic             eoramp_i,
  input  logic             tick_10ms_i,
  input  logic             tick_1ms_i,
  output logic             start_ramp_o,
  output logic             start_sar_o,
  output logic             start_tx_o,
  output logic             clear_buffer_o,
  output logic [CH_W-1:0]  sel_ch_o,
  output logic             busy_o,
  output logic             err_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_RAMP_START, S_SYNC10, S_SAR_START, S_SAR_WAIT,
    S_TX_START, S_TX_WAIT, S_SYNC1, S_CLEAR, S_ERROR
  } state_t;

  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NCH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_t            r_state;
  logic [CH_W-1:0]   r_sel;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_sweep;
  logic              r_ramp_done;
  logic              w_abort;
  logic              w_tmo_exp;

  assign w_abort   = abort_i && (r_state != S_IDLE);
  assign w_tmo_exp = (r_tmo == TMO_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_tmo       <= '0;
      r_sweep     <= 1'b0;
      r_ramp_done <= 1'b0;
    end else begin
      if (w_abort) begin
        r_state <= S_CLEAR;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_sel       <= '0;
            r_ramp_done <= 1'b0;
            if (eor_i) begin
              r_sweep <= (cmd_buffer_i == CMD_SWEEP);
              r_state <= S_DECODE;
            end
          end
          // Command is still valid the cycle after eor_i, so decode it here.
          S_DECODE: begin
            if (cmd_buffer_i == CMD_SINGLE)     r_state <= S_SAR_START;
            else if (cmd_buffer_i == CMD_SWEEP) r_state <= S_RAMP_START;
            else                                r_state <= S_CLEAR;
          end
          S_RAMP_START: r_state <= S_SYNC10;
          S_SYNC10:     if (tick_10ms_i) r_state <= S_SAR_START;
          S_SAR_START: begin
            r_tmo   <= '0;
            r_state <= S_SAR_WAIT;
          end
          S_SAR_WAIT: begin
            if (eosar_i)        r_state <= S_TX_START;
            else if (w_tmo_exp) r_state <= S_ERROR;
            else                r_tmo   <= r_tmo + 1'b1;
          end
          S_TX_START: begin
            r_tmo   <= '0;
            r_state <= S_TX_WAIT;
          end
          S_TX_WAIT: begin
            if (eot_i) begin
              if (r_sel < LAST_CH) begin
                r_sel   <= r_sel + 1'b1;
                r_state <= S_SAR_START;
              end else begin
                r_sel <= '0;
                if (!r_sweep || r_ramp_done || eoramp_i) r_state <= S_IDLE;
                else                                     r_state <= S_SYNC1;
              end
            end else if (w_tmo_exp) begin
              r_state <= S_ERROR;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          S_SYNC1:  if (tick_1ms_i) r_state <= S_SAR_START;
          S_CLEAR:  r_state <= S_IDLE;
          S_ERROR:  r_state <= S_IDLE;
          default:  r_state <= S_IDLE;
        endcase
      end
      if (r_sweep && (r_state != S_IDLE) && eoramp_i) r_ramp_done <= 1'b1;
    end
  end

  // Start pulses are suppressed in an abort cycle so downstream blocks never see a stray start.
  assign start_ramp_o   = (r_state == S_RAMP_START) && !abort_i;
  assign start_sar_o    = (r_state == S_SAR_START)  && !abort_i;
  assign start_tx_o     = (r_state == S_TX_START)   && !abort_i;
  assign clear_buffer_o = (r_state == S_CLEAR) || (r_state == S_ERROR);
  assign err_o          = (r_state == S_ERROR);
  assign busy_o         = (r_state != S_IDLE);
  assign sel_ch_o       = r_sel;

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer: expected pulse events queued by stimulus, popped by a monitor.
module tb_acq_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] cmd_buffer_i = '0;
  logic       eor_i = 0, abort_i = 0, eosar_i = 0, eot_i = 0, eoramp_i = 0;
  logic       tick_10ms_i = 0, tick_1ms_i = 0;
  logic       start_ramp_o, start_sar_o, start_tx_o, clear_buffer_o, busy_o, err_o;
  logic [1:0] sel_ch_o;

  acq_sequencer #(.WIDTH(8), .NCH(4), .TMO_W(16), .TMO_CYC(20)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_buffer_i(cmd_buffer_i), .eor_i(eor_i),
    .abort_i(abort_i), .eosar_i(eosar_i), .eot_i(eot_i), .eoramp_i(eoramp_i),
    .tick_10ms_i(tick_10ms_i), .tick_1ms_i(tick_1ms_i),
    .start_ramp_o(start_ramp_o), .start_sar_o(start_sar_o), .start_tx_o(start_tx_o),
    .clear_buffer_o(clear_buffer_o), .sel_ch_o(sel_ch_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Pulse vector order: {ramp, sar, tx, clear, err}
  localparam logic [4:0] P_RAMP = 5'b10000, P_SAR = 5'b01000, P_TX = 5'b00100,
                         P_CLR = 5'b00010, P_ERR = 5'b00011;

  typedef struct packed {
    logic [4:0] p;
    logic [1:0] sel;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0, n_bad = 0;
  int  cyc = 0;
  int  sar_cyc = 0, err_cyc = 0;
  int  sar_dly = 5;
  bit  no_sar = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] p, input int sel);
    ev_t e;
    e.p = p;
    e.sel = 2'(sel);
    exp_q.push_back(e);
  endtask

  task automatic push_pass();
    for (int ch = 0; ch < 4; ch++) begin
      push(P_SAR, ch);
      push(P_TX, ch);
    end
  endtask

  task automatic send_cmd(input logic [7:0] c);
    @(negedge clk_i);
    cmd_buffer_i = c;
    eor_i = 1'b1;
    @(negedge clk_i);
    eor_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int k = 0;
    while (busy_o && k < max) begin
      @(negedge clk_i);
      k++;
    end
    check(name, busy_o, 0);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  // Monitor: every cycle with a pulse output must match the head of the expected queue.
  initial begin
    ev_t a, e;
    forever begin
      @(negedge clk_i);
      a.p   = {start_ramp_o, start_sar_o, start_tx_o, clear_buffer_o, err_o};
      a.sel = sel_ch_o;
      if (!rst_i && a.p != '0) begin
        if (start_sar_o) sar_cyc = cyc;
        if (err_o)       err_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got pulses=%b sel=%0d with nothing expected", a.p, a.sel);
        end else begin
          e = exp_q.pop_front();
          check("event", int'(a), int'(e));
        end
      end
    end
  end

  // SAR responder: eosar_i sar_dly cycles after start_sar_o, unless withheld.
  initial begin
    forever begin
      @(negedge clk_i);
      if (start_sar_o && !no_sar) begin
        repeat (sar_dly) @(negedge clk_i);
        eosar_i = 1'b1;
        @(negedge clk_i);
        eosar_i = 1'b0;
      end
    end
  end

  // TX responder: eot_i 5 cycles after start_tx_o.
  initial begin
    forever begin
      @(negedge clk_i);
      if (start_tx_o) begin
        repeat (5) @(negedge clk_i);
        eot_i = 1'b1;
        @(negedge clk_i);
        eot_i = 1'b0;
      end
    end
  end

  initial begin
    int k;
    repeat (3) @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_pulses", {start_ramp_o, start_sar_o, start_tx_o, clear_buffer_o, err_o}, 0);
    check("rst_sel", sel_ch_o, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Single pass over four channels
    push_pass();
    send_cmd(8'h01);
    wait_idle("single_idle", 300);
    repeat (5) @(negedge clk_i);

    // Sweep: ramp, 10 ms sync, pass, 1 ms sync, eoramp during SYNC1, final pass
    push(P_RAMP, 0);
    push_pass();
    push_pass();
    send_cmd(8'h02);
    repeat (4) @(negedge clk_i);
    check("sync10_busy", busy_o, 1);
    tick_10ms_i = 1'b1;
    @(negedge clk_i);
    tick_10ms_i = 1'b0;
    repeat (60) @(negedge clk_i);
    check("sync1_busy", busy_o, 1);
    check("sweep_pass1_left", exp_q.size(), 8);
    eoramp_i = 1'b1;
    @(negedge clk_i);
    eoramp_i = 1'b0;
    repeat (2) @(negedge clk_i);
    tick_1ms_i = 1'b1;
    @(negedge clk_i);
    tick_1ms_i = 1'b0;
    wait_idle("sweep_idle", 300);
    repeat (5) @(negedge clk_i);

    // Unknown command: one clear pulse, idle within 3 clocks of eor
    push(P_CLR, 0);
    send_cmd(8'h7F);
    repeat (2) @(negedge clk_i);
    check("badcmd_idle3", busy_o, 0);
    check("badcmd_pending", exp_q.size(), 0);
    repeat (5) @(negedge clk_i);

    // Watchdog expiry in SAR_WAIT
    no_sar = 1;
    push(P_SAR, 0);
    push(P_ERR, 0);
    send_cmd(8'h01);
    wait_idle("tmo_idle", 100);
    check("sar_to_err_clks", err_cyc - sar_cyc, 21);
    no_sar = 0;
    repeat (5) @(negedge clk_i);

    // eosar on the expiry cycle wins over the timeout
    sar_dly = 20;
    push_pass();
    send_cmd(8'h01);
    wait_idle("edge_idle", 400);
    sar_dly = 5;
    repeat (5) @(negedge clk_i);

    // Abort in TX_WAIT on channel 2
    push(P_SAR, 0); push(P_TX, 0);
    push(P_SAR, 1); push(P_TX, 1);
    push(P_SAR, 2); push(P_TX, 2);
    push(P_CLR, 2);
    send_cmd(8'h01);
    k = 0;
    while (!(start_tx_o && sel_ch_o == 2'd2) && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    check("abort_found_tx2", k < 200, 1);
    @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("abort_clear_next", clear_buffer_o, 1);
    wait_idle("abort_idle", 10);
    repeat (2) @(negedge clk_i);
    check("abort_sel0", sel_ch_o, 0);
    repeat (10) @(negedge clk_i);

    // Async reset in SAR_WAIT, then a normal single command
    no_sar = 1;
    push(P_SAR, 0);
    send_cmd(8'h01);
    repeat (4) @(negedge clk_i);
    check("pre_rst_busy", busy_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_busy", busy_o, 0);
    check("async_rst_pulses", {start_ramp_o, start_sar_o, start_tx_o, clear_buffer_o, err_o}, 0);
    check("async_rst_sel", sel_ch_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    no_sar = 0;
    repeat (2) @(negedge clk_i);
    push_pass();
    send_cmd(8'h01);
    wait_idle("post_rst_idle", 300);
    repeat (10) @(negedge clk_i);
    check("final_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
